pipeline_sequencer: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline (fetch/decode/execute/memory/writeback).

---
 rtl/custom_types_pkg.sv | 43 ++++
 rtl/pipeline_hazard_detect.sv | 18 +
 rtl/pipeline_sequencer.sv | 147 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/custom_types_pkg.sv
// Shared pipeline control types: register-index type, sequencer FSM
// state encoding, and the bundled latch/PC control word.
package custom_types_pkg;

    localparam int unsigned REG_W_DEF = 5;

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_WAIT = 3'd1,
        LU_STALL = 3'd2,
        HALTED   = 3'd3
    } hazard_state_t;

    // One bus carrying every enable/flush/PC control bit to the datapath.
    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic mw_en;
        logic fd_flush;
        logic de_flush;
        logic em_flush;
        logic mw_flush;
    } pipe_ctrl_t;

    // Normal forward progress; an I-cache miss injects a bubble into decode.
    function automatic pipe_ctrl_t ctrl_advance(input logic ihit);
        pipe_ctrl_t c;
        c          = '0;
        c.pc_en    = ihit;
        c.fd_en    = 1'b1;
        c.de_en    = 1'b1;
        c.em_en    = 1'b1;
        c.mw_en    = 1'b1;
        c.fd_flush = ~ihit;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Load-use hazard compare between the ID/EX load destination and the
// IF/ID source registers. Purely combinational; also usable by forwarding.
module pipeline_hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             uses_rt_i,
    input  logic [REG_W-1:0] rw_i,
    input  logic             dren_i,
    output logic             hazard_o
);

    // Register 0 is hardwired and never creates a dependency.
    assign hazard_o = dren_i && (rw_i != '0) &&
                      ((rw_i == rs_i) || (uses_rt_i && (rw_i == rt_i)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional stall counters are enabled by defining PIPE_STALL_COUNTERS_EN.
module pipeline_sequencer
    import custom_types_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    input  logic [REG_W-1:0] de_rw,
    input  logic             de_dren,
    input  logic             em_dren,
    input  logic             em_dwen,
    input  logic             em_mispredict,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             halted,
`ifdef PIPE_STALL_COUNTERS_EN
    output logic [CNT_W-1:0] cnt_mem_stall,
    output logic [CNT_W-1:0] cnt_lu_stall,
    output logic [CNT_W-1:0] cnt_flush,
`endif
    output logic [2:0]       state_o
);

    hazard_state_t state_q, state_d;
    pipe_ctrl_t    ctl;
    logic          halted_q;
    logic          lu_hazard;
    logic          mem_busy;
    logic          halt_win;

    pipeline_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .rs_i      (fd_rs),
        .rt_i      (fd_rt),
        .uses_rt_i (fd_uses_rt),
        .rw_i      (de_rw),
        .dren_i    (de_dren),
        .hazard_o  (lu_hazard)
    );

    assign mem_busy = (em_dren || em_dwen) && !dhit;
    assign halt_win = wb_halt || (state_q == HALTED);

    // MEM_WAIT and LU_STALL only track history; outputs are decided by the
    // live event priority, so the dhit cycle of a memory wait advances normally.
    always_comb begin
        ctl     = '0;
        state_d = state_q;
        if (RST) begin
            ctl.fd_flush = 1'b1;
            ctl.de_flush = 1'b1;
            ctl.em_flush = 1'b1;
            ctl.mw_flush = 1'b1;
            state_d      = RUN;
        end else if (halt_win) begin
            state_d = HALTED;
        end else if (mem_busy) begin
            ctl.mw_en    = 1'b1;
            ctl.mw_flush = 1'b1;
            state_d      = MEM_WAIT;
        end else if (em_mispredict) begin
            ctl             = ctrl_advance(1'b1);
            ctl.pc_redirect = 1'b1;
            ctl.fd_flush    = 1'b1;
            ctl.de_flush    = 1'b1;
            ctl.em_flush    = 1'b1;
            state_d         = RUN;
        end else if (lu_hazard) begin
            ctl          = ctrl_advance(ihit);
            ctl.pc_en    = 1'b0;
            ctl.fd_en    = 1'b0;
            ctl.fd_flush = 1'b0;
            ctl.de_flush = 1'b1;
            state_d      = LU_STALL;
        end else begin
            ctl     = ctrl_advance(ihit);
            state_d = RUN;
        end
    end

    // State register and sticky halt flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
        end
    end

`ifdef PIPE_STALL_COUNTERS_EN
    logic [CNT_W-1:0] cnt_mem_q, cnt_lu_q, cnt_flush_q;
    logic             act_mem, act_lu, act_flush;

    assign act_mem   = !halt_win && mem_busy;
    assign act_flush = !halt_win && !mem_busy && em_mispredict;
    assign act_lu    = !halt_win && !mem_busy && !em_mispredict && lu_hazard;

    // Saturating per-cause counters; frozen once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_mem_q   <= '0;
            cnt_lu_q    <= '0;
            cnt_flush_q <= '0;
        end else if (state_q != HALTED) begin
            if (act_mem && (cnt_mem_q != '1))     cnt_mem_q   <= cnt_mem_q + CNT_W'(1);
            if (act_lu && (cnt_lu_q != '1))       cnt_lu_q    <= cnt_lu_q + CNT_W'(1);
            if (act_flush && (cnt_flush_q != '1)) cnt_flush_q <= cnt_flush_q + CNT_W'(1);
        end
    end

    assign cnt_mem_stall = cnt_mem_q;
    assign cnt_lu_stall  = cnt_lu_q;
    assign cnt_flush     = cnt_flush_q;
`endif

    assign pc_en       = ctl.pc_en;
    assign pc_redirect = ctl.pc_redirect;
    assign fd_en       = ctl.fd_en;
    assign de_en       = ctl.de_en;
    assign em_en       = ctl.em_en;
    assign mw_en       = ctl.mw_en;
    assign fd_flush    = ctl.fd_flush;
    assign de_flush    = ctl.de_flush;
    assign em_flush    = ctl.em_flush;
    assign mw_flush    = ctl.mw_flush;
    assign halted      = halted_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer. Control outputs are compared as
// {pc_en,pc_redirect,fd_en,de_en,em_en,mw_en,fd_flush,de_flush,em_flush,mw_flush}.
module tb_pipeline_sequencer;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit;
    logic [REG_W-1:0] fd_rs, fd_rt, de_rw;
    logic             fd_uses_rt, de_dren, em_dren, em_dwen, em_mispredict, wb_halt;
    logic             pc_en, pc_redirect, fd_en, de_en, em_en, mw_en;
    logic             fd_flush, de_flush, em_flush, mw_flush, halted;
    logic [2:0]       state_o;
`ifdef PIPE_STALL_COUNTERS_EN
    logic [CNT_W-1:0] cnt_mem_stall, cnt_lu_stall, cnt_flush;
`endif
    logic [9:0]       ctl;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_fail  = 0;

    localparam logic [9:0] C_RESET = 10'b00_0000_1111;
    localparam logic [9:0] C_RUN   = 10'b10_1111_0000;
    localparam logic [9:0] C_MISS  = 10'b00_1111_1000;
    localparam logic [9:0] C_LU    = 10'b00_0111_0100;
    localparam logic [9:0] C_MEM   = 10'b00_0001_0001;
    localparam logic [9:0] C_REDIR = 10'b11_1111_1110;
    localparam logic [9:0] C_HALT  = 10'b00_0000_0000;

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, pc_redirect, fd_en, de_en, em_en, mw_en,
                  fd_flush, de_flush, em_flush, mw_flush};

    pipeline_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ihit          (ihit),
        .dhit          (dhit),
        .fd_rs         (fd_rs),
        .fd_rt         (fd_rt),
        .fd_uses_rt    (fd_uses_rt),
        .de_rw         (de_rw),
        .de_dren       (de_dren),
        .em_dren       (em_dren),
        .em_dwen       (em_dwen),
        .em_mispredict (em_mispredict),
        .wb_halt       (wb_halt),
        .pc_en         (pc_en),
        .pc_redirect   (pc_redirect),
        .fd_en         (fd_en),
        .de_en         (de_en),
        .em_en         (em_en),
        .mw_en         (mw_en),
        .fd_flush      (fd_flush),
        .de_flush      (de_flush),
        .em_flush      (em_flush),
        .mw_flush      (mw_flush),
        .halted        (halted),
`ifdef PIPE_STALL_COUNTERS_EN
        .cnt_mem_stall (cnt_mem_stall),
        .cnt_lu_stall  (cnt_lu_stall),
        .cnt_flush     (cnt_flush),
`endif
        .state_o       (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1;
        fd_rs = 5'd1; fd_rt = 5'd2; fd_uses_rt = 1'b0;
        de_rw = 5'd0; de_dren = 1'b0;
        em_dren = 1'b0; em_dwen = 1'b0; em_mispredict = 1'b0; wb_halt = 1'b0;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;

        // Reset held two cycles
        #1; chk("rst_ctl_c1", 32'(ctl), 32'(C_RESET));
        tick();  chk("rst_ctl_c2", 32'(ctl), 32'(C_RESET));
        tick();
        RST = 1'b0; #1;
        chk("rel_state", 32'(state_o), 32'd0);
        chk("rel_ctl", 32'(ctl), 32'(C_RUN));
        chk("rel_halted", 32'(halted), 32'd0);

        // Load-use on Rs
        de_dren = 1'b1; de_rw = 5'd5; fd_rs = 5'd5; #1;
        chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        tick();
        idle_inputs(); #1;
        chk("lu_stall_state", 32'(state_o), 32'd2);
        chk("lu_stall_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        chk("lu_back_run", 32'(state_o), 32'd0);

        // Load-use on Rt only when Rt is read
        de_dren = 1'b1; de_rw = 5'd7; fd_rt = 5'd7; fd_uses_rt = 1'b1; #1;
        chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        tick();
        fd_uses_rt = 1'b0; #1;
        chk("lu_rt_unused_ctl", 32'(ctl), 32'(C_RUN));
        chk("lu_rt_state", 32'(state_o), 32'd2);
        tick();

        // Destination register 0 never stalls
        idle_inputs();
        de_dren = 1'b1; de_rw = 5'd0; fd_rs = 5'd0; #1;
        chk("lu_r0_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        idle_inputs();

        // I-cache miss bubble
        ihit = 1'b0; #1;
        chk("imiss_ctl", 32'(ctl), 32'(C_MISS));
        tick();
        ihit = 1'b1;

        // D-cache miss: three stall cycles, then dhit
        em_dren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mem_stall_ctl", 32'(ctl), 32'(C_MEM));
            chk("mem_stall_state", 32'(state_o), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        dhit = 1'b1; #1;
        chk("mem_dhit_state", 32'(state_o), 32'd1);
        chk("mem_dhit_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        idle_inputs(); #1;
        chk("mem_after_state", 32'(state_o), 32'd0);
`ifdef PIPE_STALL_COUNTERS_EN
        chk("cnt_mem_3", cnt_mem_stall, 32'd3);
        chk("cnt_lu_2", cnt_lu_stall, 32'd2);
`endif

        // Mispredict beats !ihit and load-use
        em_mispredict = 1'b1; ihit = 1'b0;
        de_dren = 1'b1; de_rw = 5'd5; fd_rs = 5'd5; #1;
        chk("redir_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        idle_inputs(); #1;
        chk("redir_next_state", 32'(state_o), 32'd0);
`ifdef PIPE_STALL_COUNTERS_EN
        chk("cnt_flush_1", cnt_flush, 32'd1);
        chk("cnt_lu_still_2", cnt_lu_stall, 32'd2);
`endif

        // Memory wait beats mispredict; redirect in the dhit cycle
        em_dren = 1'b1; dhit = 1'b0; em_mispredict = 1'b1; #1;
        chk("memmis_ctl", 32'(ctl), 32'(C_MEM));
        tick();
        chk("memmis_state", 32'(state_o), 32'd1);
        dhit = 1'b1; #1;
        chk("memmis_dhit_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        idle_inputs(); #1;
        chk("memmis_after_state", 32'(state_o), 32'd0);
`ifdef PIPE_STALL_COUNTERS_EN
        chk("cnt_mem_4", cnt_mem_stall, 32'd4);
        chk("cnt_flush_2", cnt_flush, 32'd2);
`endif

        // Halt
        wb_halt = 1'b1; #1;
        chk("halt_ctl", 32'(ctl), 32'(C_HALT));
        chk("halt_not_yet", 32'(halted), 32'd0);
        tick();
        wb_halt = 1'b0; #1;
        chk("halted_set", 32'(halted), 32'd1);
        chk("halted_state", 32'(state_o), 32'd3);
        for (int i = 0; i < 10; i++) begin
            ihit = 1'($urandom); dhit = 1'($urandom);
            fd_rs = 5'($urandom); fd_rt = 5'($urandom); fd_uses_rt = 1'($urandom);
            de_rw = 5'($urandom); de_dren = 1'($urandom);
            em_dren = 1'($urandom); em_dwen = 1'($urandom);
            em_mispredict = 1'($urandom); wb_halt = 1'($urandom);
            #1;
            chk("halted_sticky", 32'(halted), 32'd1);
            chk("halted_ctl", 32'(ctl), 32'(C_HALT));
            tick();
        end
`ifdef PIPE_STALL_COUNTERS_EN
        chk("cnt_mem_frozen", cnt_mem_stall, 32'd4);
        chk("cnt_flush_frozen", cnt_flush, 32'd2);
`endif
        RST = 1'b1; #1;
        chk("halt_rst_ctl", 32'(ctl), 32'(C_RESET));
        tick();
        RST = 1'b0;
        idle_inputs(); #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_state", 32'(state_o), 32'd0);
        chk("halt_rst_run_ctl", 32'(ctl), 32'(C_RUN));
`ifdef PIPE_STALL_COUNTERS_EN
        chk("cnt_cleared", cnt_mem_stall, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
